// File: rtl/uart_rx_sampler.sv
// ============================================================================
//  Module      : uart_rx_sampler
//  Description : Serial receive front end. Detects the start bit, takes a
//                3-sample majority vote at each bit centre, assembles
//                DATA_BITS bits LSB first, then checks optional parity and
//                the stop bit. Optional parity: UART_RX_SAMPLER_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_sampler #(
    parameter int SAMPLE_RATIO = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 sample_clk,
    input  logic                 reset,
    input  logic                 din,
    output logic                 sample_sig,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int c_CW = $clog2(SAMPLE_RATIO);
    localparam int c_IW = $clog2(DATA_BITS);

    localparam logic [c_CW-1:0] c_HALF_M1  = c_CW'(SAMPLE_RATIO / 2 - 1);
    localparam logic [c_CW-1:0] c_HALF     = c_CW'(SAMPLE_RATIO / 2);
    localparam logic [c_CW-1:0] c_HALF_P1  = c_CW'(SAMPLE_RATIO / 2 + 1);
    localparam logic [c_CW-1:0] c_LAST     = c_CW'(SAMPLE_RATIO - 1);
    localparam logic [c_IW-1:0] c_IDX_LAST = c_IW'(DATA_BITS - 1);

    localparam logic [2:0] c_IDLE       = 3'd0;
    localparam logic [2:0] c_START      = 3'd1;
    localparam logic [2:0] c_DATA       = 3'd2;
    localparam logic [2:0] c_STOP       = 3'd4;
    localparam logic [2:0] c_BREAK_WAIT = 3'd5;
`ifdef UART_RX_SAMPLER_PARITY_EN
    localparam logic [2:0] c_PARITY     = 3'd3;
`endif

    logic [2:0]           r_state;
    logic [2:0]           w_next_state;
    logic [c_CW-1:0]      r_count;
    logic [c_IW-1:0]      r_idx;
    logic                 r_samp_a;
    logic                 r_samp_b;
    logic [DATA_BITS-1:0] r_shift;
    logic                 w_mid;
    logic                 w_wrap;
    logic                 w_vote;

    assign w_mid  = (r_count == c_HALF_P1);
    assign w_wrap = (r_count == c_LAST);
    // Third sample is the live line value at the HALF+1 edge.
    assign w_vote = (r_samp_a & r_samp_b) | (r_samp_a & din) | (r_samp_b & din);

    always_ff @(posedge sample_clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (!din) w_next_state = c_START;
            end
            c_START: begin
                if (w_mid && w_vote) w_next_state = c_IDLE;
                else if (w_wrap)     w_next_state = c_DATA;
            end
            c_DATA: begin
                if (w_wrap && (r_idx == c_IDX_LAST)) begin
`ifdef UART_RX_SAMPLER_PARITY_EN
                    w_next_state = c_PARITY;
`else
                    w_next_state = c_STOP;
`endif
                end
            end
`ifdef UART_RX_SAMPLER_PARITY_EN
            c_PARITY: begin
                if (w_wrap) w_next_state = c_STOP;
            end
`endif
            c_STOP: begin
                // Decide at mid-stop so a back-to-back start edge is not lost.
                if (w_mid) w_next_state = w_vote ? c_IDLE : c_BREAK_WAIT;
            end
            c_BREAK_WAIT: begin
                if (din) w_next_state = c_IDLE;
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        sample_sig = 1'b0;
        busy       = 1'b0;
        if ((r_state == c_DATA) && w_mid) sample_sig = 1'b1;
        if (r_state != c_IDLE)            busy       = 1'b1;
    end

`ifdef UART_RX_SAMPLER_PARITY_EN
    logic r_par;
    logic w_par_err;

    assign w_par_err = r_par ^ (^r_shift) ^ 1'(PARITY_ODD);

    always_ff @(posedge sample_clk) begin
        if (reset) begin
            r_par <= 1'b0;
        end else if ((r_state == c_PARITY) && w_mid) begin
            r_par <= w_vote;
        end
    end
`else
    logic w_par_err;
    logic w_unused_parity_odd;

    assign w_par_err           = 1'b0;
    assign w_unused_parity_odd = 1'(PARITY_ODD);
`endif

    always_ff @(posedge sample_clk) begin
        if (reset) begin
            r_count    <= '0;
            r_idx      <= '0;
            r_samp_a   <= 1'b0;
            r_samp_b   <= 1'b0;
            r_shift    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            data_valid <= 1'b0;

            if ((w_next_state == c_IDLE) || (w_next_state == c_BREAK_WAIT)) begin
                r_count <= '0;
            end else if (r_state == c_IDLE) begin
                r_count <= c_CW'(1);
            end else if (w_wrap) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + c_CW'(1);
            end

            if (r_count == c_HALF_M1) r_samp_a <= din;
            if (r_count == c_HALF)    r_samp_b <= din;

            if (r_state == c_START) begin
                r_idx <= '0;
            end else if ((r_state == c_DATA) && w_wrap && (r_idx != c_IDX_LAST)) begin
                r_idx <= r_idx + c_IW'(1);
            end

            if ((r_state == c_DATA) && w_mid) r_shift[r_idx] <= w_vote;

            if ((r_state == c_STOP) && w_mid) begin
                data_out   <= r_shift;
                data_valid <= 1'b1;
                frame_err  <= ~w_vote;
                parity_err <= w_par_err;
            end
        end
    end

endmodule

`default_nettype wire
